// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, result {remainder, quotient}.
// Latency 33 cycles from accepted start to done (1 cycle for a zero divisor); start is ignored while busy/done.
module divider #(
  parameter int          WIDTH = 32,
  parameter logic [5:0]  DIVU  = 6'b011011
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  input  logic [5:0]           Signal,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   dataOut
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;

  // The partial remainder is always < divisor after a step, so only the shifted
  // value needs the extra bit for the compare/subtract.
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_sub;
  logic             ge;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    r_sh   = {r, q[WIDTH-1]};
    r_sub  = r_sh - {1'b0, d};
    ge     = (r_sh >= {1'b0, d});
    r_next = ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
    q_next = {q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
      div_by_zero <= 1'b0;
      dataOut     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (Signal == DIVU)) begin
            d           <= dataB;
            q           <= dataA;
            r           <= '0;
            count       <= '0;
            div_by_zero <= 1'b0;
            if (dataB == '0) begin
              // Short path: same answer the full algorithm would reach.
              r           <= dataA;
              q           <= '1;
              div_by_zero <= 1'b1;
              dataOut     <= {dataA, {WIDTH{1'b1}}};
              state       <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          r     <= r_next;
          q     <= q_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            dataOut <= {r_next, q_next};
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: cycle-level behavioural model plus directed hand-computed cases.
module tb_divider;

  localparam logic [5:0] DIVU = 6'b011011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [63:0] dataOut;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  divider dut (
    .clk         (clk),
    .reset       (reset),
    .dataA       (dataA),
    .dataB       (dataB),
    .Signal      (Signal),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .dataOut     (dataOut)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: an accepted divide is busy for 32 cycles then done for one; zero divisor goes straight to done.
  int          m_left = 0;
  bit          m_done = 1'b0;
  bit          m_dbz  = 1'b0;
  logic [63:0] m_out  = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk or negedge reset) begin : model
    bit was_done;
    if (!reset) begin
      m_left = 0;
      m_done = 1'b0;
      m_dbz  = 1'b0;
      m_out  = '0;
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_out  = m_pend;
        end
      end else if (!was_done && start && Signal == DIVU) begin
        m_dbz = 1'b0;
        if (dataB == 0) begin
          m_done = 1'b1;
          m_dbz  = 1'b1;
          m_out  = {dataA, 32'hFFFF_FFFF};
        end else begin
          m_left = 32;
          m_pend = {dataA % dataB, dataA / dataB};
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", {63'd0, busy}, {63'd0, m_left > 0});
      chk("cyc_done", {63'd0, done}, {63'd0, m_done});
      chk("cyc_dbz", {63'd0, div_by_zero}, {63'd0, m_dbz});
      chk("cyc_dataOut", dataOut, m_out);
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig);
    @(negedge clk);
    dataA  = a;
    dataB  = b;
    Signal = sig;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input logic [63:0] exp_out,
                           input logic exp_dbz);
    int lat   = 0;
    int nbusy = 0;
    bit seen  = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    if (!seen) begin
      chk({name, "_timeout"}, {63'd0, done}, 64'd1);
    end else begin
      chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({name, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat - 1));
      chk({name, "_dataOut"}, dataOut, exp_out);
      chk({name, "_dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    chk("reset_dataOut", dataOut, 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    cmp_en = 1'b1;

    launch(32'd100, 32'd7, DIVU);
    wait_done("basic", 33, {32'd2, 32'd14}, 1'b0);
    chk("model_basic", m_out, {32'd2, 32'd14});

    launch(32'd3, 32'd10, DIVU);
    wait_done("small", 33, {32'd3, 32'd0}, 1'b0);

    launch(32'hFFFF_FFFF, 32'd1, DIVU);
    wait_done("maxdiv", 33, {32'd0, 32'hFFFF_FFFF}, 1'b0);

    launch(32'hFFFF_FFFF, 32'h8000_0000, DIVU);
    wait_done("bigdivisor", 33, {32'h7FFF_FFFF, 32'd1}, 1'b0);
    chk("model_bigdivisor", m_out, {32'h7FFF_FFFF, 32'd1});

    launch(32'd5, 32'd0, DIVU);
    wait_done("divzero", 1, {32'd5, 32'hFFFF_FFFF}, 1'b1);
    repeat (3) @(negedge clk);
    chk("divzero_held", {63'd0, div_by_zero}, 64'd1);

    launch(32'd1000, 32'd33, DIVU);
    wait_done("after_zero", 33, {32'd10, 32'd30}, 1'b0);

    // Immediately after DONE: accepted on the following IDLE cycle.
    launch(32'd7, 32'd7, DIVU);
    wait_done("back2back", 33, {32'd0, 32'd1}, 1'b0);

    launch(32'd100, 32'd7, 6'b011001);
    repeat (3) @(negedge clk);
    chk("badsig_busy", {63'd0, busy}, 64'd0);
    chk("badsig_done", {63'd0, done}, 64'd0);

    launch(32'd100, 32'd7, DIVU);
    repeat (5) @(negedge clk);
    dataA  = 32'd50;
    dataB  = 32'd3;
    Signal = DIVU;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dataA  = 32'd9;
    dataB  = 32'd0;
    wait_done("repulse", 28, {32'd2, 32'd14}, 1'b0);

    launch(32'd1000, 32'd33, DIVU);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_done", {63'd0, done}, 64'd0);
    chk("midreset_dataOut", dataOut, 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;

    launch(32'd100, 32'd7, DIVU);
    wait_done("post_reset", 33, {32'd2, 32'd14}, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
